// File: rtl/led_display_ctrl.sv
// Registered LED display controller: count value -> NUM_LEDS pins in BINARY, BAR, CHANGE or TEST mode, with global PWM.
// Latency: 2 clocks from count/mode to leds (input register stage, then output pin register).
// Backpressure: none; free-running datapath. Optional macro LED_DISP_PWM_EN builds the brightness PWM (otherwise lit bits are always on).
module led_display_ctrl #(
    parameter int CNT_W      = 4,
    parameter int NUM_LEDS   = 6,
    parameter int PWM_W      = 4,
    parameter int FLASH_CYC  = 2700000,
    parameter int STEP_CYC   = 13500000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [CNT_W-1:0]    count,
    input  logic [1:0]          mode,
    input  logic [PWM_W-1:0]    brightness,
    output logic [NUM_LEDS-1:0] leds
);

    // Parameter sanity: the parity pair needs two LEDs above the count field.
    if (NUM_LEDS < CNT_W + 2) begin : g_bad_num_leds
        $error("led_display_ctrl: NUM_LEDS must be >= CNT_W+2");
    end
    if (FLASH_CYC < 1) begin : g_bad_flash_cyc
        $error("led_display_ctrl: FLASH_CYC must be >= 1");
    end
    if (STEP_CYC < 1) begin : g_bad_step_cyc
        $error("led_display_ctrl: STEP_CYC must be >= 1");
    end

    localparam int TMR_W  = (FLASH_CYC > 1) ? $clog2(FLASH_CYC) : 1;
    localparam int STEP_W = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam int POS_W  = $clog2(NUM_LEDS);

    localparam logic [1:0] MODE_BINARY = 2'd0;
    localparam logic [1:0] MODE_BAR    = 2'd1;
    localparam logic [1:0] MODE_CHANGE = 2'd2;
    localparam logic [1:0] MODE_TEST   = 2'd3;

    localparam logic [0:0] ST_SHOW  = 1'b0;
    localparam logic [0:0] ST_FLASH = 1'b1;

    // Pin value that leaves every LED dark for the configured polarity.
    localparam logic [NUM_LEDS-1:0] LEDS_OFF = (ACTIVE_LOW != 0) ? {NUM_LEDS{1'b1}} : {NUM_LEDS{1'b0}};

    localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(FLASH_CYC - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYC - 1);
    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(NUM_LEDS - 1);

    // Stage-1 input registers and the one-cycle-older copies used for change detection.
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    count_prev_q, count_prev_d;
    logic [1:0]          mode_q, mode_d;
    logic [1:0]          mode_prev_q, mode_prev_d;

    // CHANGE-mode FSM and flash timer.
    logic [0:0]          state_q, state_d;
    logic [TMR_W-1:0]    timer_q, timer_d;

    // TEST-mode walker.
    logic [STEP_W-1:0]   step_q, step_d;
    logic [POS_W-1:0]    pos_q, pos_d;

    // Output pin register.
    logic [NUM_LEDS-1:0] leds_q, leds_d;

    logic                mode_chg;
    logic                cnt_chg;
    logic                pwm_on;
    logic [NUM_LEDS-1:0] pat_binary;
    logic [NUM_LEDS-1:0] pat_bar;
    logic [NUM_LEDS-1:0] pat_test;
    logic [NUM_LEDS-1:0] pattern;

    assign mode_chg = (mode_q != mode_prev_q);
    assign cnt_chg  = (count_q != count_prev_q);

    // Stage-1 next state: capture inputs and age the previous copies by one clock.
    always_comb begin
        count_d      = count;
        mode_d       = mode;
        count_prev_d = count_q;
        mode_prev_d  = mode_q;
    end

    // Stage-1 registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            count_q      <= '0;
            count_prev_q <= '0;
            mode_q       <= '0;
            mode_prev_q  <= '0;
        end else begin
            count_q      <= count_d;
            count_prev_q <= count_prev_d;
            mode_q       <= mode_d;
            mode_prev_q  <= mode_prev_d;
        end
    end

    // CHANGE FSM: any count change (including wrap) starts or retriggers a FLASH_CYC-clock flash.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (mode_chg || (mode_q != MODE_CHANGE)) begin
            state_d = ST_SHOW;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_SHOW: begin
                    if (cnt_chg) begin
                        state_d = ST_FLASH;
                        timer_d = TMR_LOAD;
                    end
                end
                ST_FLASH: begin
                    if (cnt_chg) begin
                        timer_d = TMR_LOAD;
                    end else if (timer_q == '0) begin
                        state_d = ST_SHOW;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
                default: begin
                    state_d = ST_SHOW;
                    timer_d = '0;
                end
            endcase
        end
    end

    // CHANGE FSM registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= ST_SHOW;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // TEST walker: held at zero outside TEST, so leaving TEST clears it and entering TEST
    // starts from position 0 with the very first TEST clock counted, giving every
    // position exactly STEP_CYC clocks on the pins.
    always_comb begin
        step_d = step_q;
        pos_d  = pos_q;
        if (mode_q != MODE_TEST) begin
            step_d = '0;
            pos_d  = '0;
        end else if (step_q == STEP_LAST) begin
            step_d = '0;
            pos_d  = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
        end else begin
            step_d = step_q + STEP_W'(1);
        end
    end

    // TEST walker registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            step_q <= '0;
            pos_q  <= '0;
        end else begin
            step_q <= step_d;
            pos_q  <= pos_d;
        end
    end

`ifdef LED_DISP_PWM_EN
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;

    // Free-running PWM counter; wraps naturally at 2^PWM_W.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    end

    // PWM counter register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    // All-ones brightness is forced fully on so the duty cycle reaches 100%.
    assign pwm_on = (brightness == {PWM_W{1'b1}}) || (pwm_cnt_q < brightness);
`else
    // Brightness is accepted but has no effect in this build.
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign pwm_on            = 1'b1;
`endif

    // Per-mode logical patterns (1 = lit).
    always_comb begin
        pat_binary               = '0;
        pat_binary[CNT_W-1:0]    = count_q;
        pat_binary[NUM_LEDS-1]   = count_q[0];
        pat_binary[NUM_LEDS-2]   = ~count_q[0];

        pat_bar = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            pat_bar[i] = (int'(count_q) > i);
        end

        pat_test        = '0;
        pat_test[pos_q] = 1'b1;
    end

    // Mode select, then PWM gating and pin polarity into the output register.
    always_comb begin
        pattern = '0;
        case (mode_q)
            MODE_BINARY: pattern = pat_binary;
            MODE_BAR:    pattern = pat_bar;
            MODE_CHANGE: pattern = (state_q == ST_FLASH) ? {NUM_LEDS{1'b1}} : pat_binary;
            MODE_TEST:   pattern = pat_test;
            default:     pattern = '0;
        endcase
        leds_d = pattern & {NUM_LEDS{pwm_on}};
        if (ACTIVE_LOW != 0) begin
            leds_d = ~leds_d;
        end
    end

    // Output pin register; dark on reset.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            leds_q <= LEDS_OFF;
        end else begin
            leds_q <= leds_d;
        end
    end

    assign leds = leds_q;

endmodule

// File: tb/tb_led_display_ctrl.sv
// Directed bench for led_display_ctrl (CNT_W=4, NUM_LEDS=6, PWM_W=2, FLASH_CYC=8, STEP_CYC=4, active-low pins).
// Inputs are driven 1 ns after a rising edge and leds are sampled at that same point, so each sample
// reflects the output register loaded on the edge just passed.
module tb_led_display_ctrl;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [3:0] count;
    logic [1:0] mode;
    logic [1:0] brightness;
    logic [5:0] leds;

    int checks   = 0;
    int failures = 0;

    always #5 sys_clk = ~sys_clk;

    led_display_ctrl #(
        .CNT_W      (4),
        .NUM_LEDS   (6),
        .PWM_W      (2),
        .FLASH_CYC  (8),
        .STEP_CYC   (4),
        .ACTIVE_LOW (1)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .count      (count),
        .mode       (mode),
        .brightness (brightness),
        .leds       (leds)
    );

    // Logical BINARY pattern {odd, even, count}.
    function automatic logic [5:0] bin(input logic [3:0] c);
        return {c[0], ~c[0], c};
    endfunction

    // Active-low pins: logical 1 (lit) drives the pin low.
    function automatic logic [5:0] pin(input logic [5:0] l);
        return ~l;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset;
        sys_rst    = 1'b0;
        count      = 4'd0;
        mode       = 2'd0;
        brightness = 2'd3;
        #1 sys_rst = 1'b1;
        #1;
        checks++;
        if (leds !== 6'b111111) begin
            failures++;
            $display("FAIL reset_state: leds=%b expected %b", leds, 6'b111111);
        end
        step(2);
        checks++;
        if (leds !== 6'b111111) begin
            failures++;
            $display("FAIL reset_hold: leds=%b expected %b", leds, 6'b111111);
        end
        sys_rst = 1'b0;
        mode    = 2'd2;
        count   = 4'd2;
        step(4);
        count = 4'd3;
        step(4);
        checks++;
        if (leds !== 6'b000000) begin
            failures++;
            $display("FAIL reset_pre_flash: leds=%b expected %b", leds, 6'b000000);
        end
        #3 sys_rst = 1'b1;
        #1;
        checks++;
        if (leds !== 6'b111111) begin
            failures++;
            $display("FAIL reset_async: leds=%b expected %b", leds, 6'b111111);
        end
        step(1);
        count      = 4'd5;
        mode       = 2'd0;
        brightness = 2'd3;
        sys_rst    = 1'b0;
        step(1);
        checks++;
        if (leds !== 6'b101111) begin
            failures++;
            $display("FAIL reset_count_zero: leds=%b expected %b", leds, 6'b101111);
        end
        step(1);
        checks++;
        if (leds !== 6'b011010) begin
            failures++;
            $display("FAIL reset_release: leds=%b expected %b", leds, 6'b011010);
        end
    endtask

    task automatic test_binary;
        logic [3:0] prev_v;
        logic [3:0] v;
        logic [5:0] e;
        mode   = 2'd0;
        prev_v = 4'd0;
        for (int i = 0; i < 18; i++) begin
            v     = (i <= 15) ? 4'(i) : 4'd0;
            count = v;
            step(1);
            if (i >= 1) begin
                e = pin(bin(prev_v));
                checks++;
                if (leds !== e) begin
                    failures++;
                    $display("FAIL binary_%0d: leds=%b expected %b", prev_v, leds, e);
                end
            end
            prev_v = v;
        end
    endtask

    task automatic test_bar;
        logic [3:0] cnt_tbl [5];
        logic [5:0] exp_tbl [5];
        cnt_tbl = '{4'd3, 4'd9, 4'd0, 4'd6, 4'd5};
        exp_tbl = '{6'b000111, 6'b111111, 6'b000000, 6'b111111, 6'b011111};
        mode = 2'd1;
        for (int i = 0; i < 5; i++) begin
            count = cnt_tbl[i];
            step(2);
            checks++;
            if (leds !== pin(exp_tbl[i])) begin
                failures++;
                $display("FAIL bar_%0d: leds=%b expected %b", cnt_tbl[i], leds, pin(exp_tbl[i]));
            end
        end
    endtask

    task automatic test_change;
        logic [5:0] e;
        mode  = 2'd0;
        count = 4'd2;
        step(3);
        mode = 2'd2;
        step(3);
        checks++;
        if (leds !== pin(bin(4'd2))) begin
            failures++;
            $display("FAIL change_show: leds=%b expected %b", leds, pin(bin(4'd2)));
        end
        // Single change 2 -> 3: one BINARY(3) sample, then 8 lit, then BINARY(3).
        count = 4'd3;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            if (k == 1)                e = pin(bin(4'd2));
            else if (k >= 3 && k <= 10) e = 6'b000000;
            else                       e = pin(bin(4'd3));
            checks++;
            if (leds !== e) begin
                failures++;
                $display("FAIL change_flash_k%0d: leds=%b expected %b", k, leds, e);
            end
        end
        // Change 3 -> 4, then 4 -> 5 detected at flash clock 5: flash extends to 8 lit after the reload.
        count = 4'd4;
        for (int k = 1; k <= 17; k++) begin
            if (k == 7) count = 4'd5;
            step(1);
            if (k == 1)                 e = pin(bin(4'd3));
            else if (k == 2)            e = pin(bin(4'd4));
            else if (k >= 3 && k <= 16) e = 6'b000000;
            else                        e = pin(bin(4'd5));
            checks++;
            if (leds !== e) begin
                failures++;
                $display("FAIL change_retrig_k%0d: leds=%b expected %b", k, leds, e);
            end
        end
    endtask

    task automatic test_walk;
        logic [5:0] e;
        mode  = 2'd0;
        count = 4'd0;
        step(3);
        mode = 2'd3;
        for (int k = 1; k <= 29; k++) begin
            step(1);
            if (k >= 2) begin
                e = 6'b000001 << (((k - 2) / 4) % 6);
                checks++;
                if (leds !== pin(e)) begin
                    failures++;
                    $display("FAIL walk_k%0d: leds=%b expected %b", k, leds, pin(e));
                end
            end
        end
        mode = 2'd0;
        step(3);
        checks++;
        if (leds !== pin(bin(4'd0))) begin
            failures++;
            $display("FAIL walk_exit: leds=%b expected %b", leds, pin(bin(4'd0)));
        end
        mode = 2'd3;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            if (k >= 2) begin
                e = 6'b000001 << (((k - 2) / 4) % 6);
                checks++;
                if (leds !== pin(e)) begin
                    failures++;
                    $display("FAIL walk_restart_k%0d: leds=%b expected %b", k, leds, pin(e));
                end
            end
        end
    endtask

    task automatic test_pwm;
        int lit;
        int bad;
        logic [1:0] b_tbl [3];
        int         exp_lit [3];
        mode  = 2'd0;
        count = 4'd15;
        step(3);
`ifdef LED_DISP_PWM_EN
        b_tbl   = '{2'd1, 2'd0, 2'd3};
        exp_lit = '{4, 0, 16};
`else
        b_tbl   = '{2'd0, 2'd1, 2'd3};
        exp_lit = '{16, 16, 16};
`endif
        for (int i = 0; i < 3; i++) begin
            brightness = b_tbl[i];
            step(2);
            lit = 0;
            bad = 0;
            for (int c = 0; c < 16; c++) begin
                step(1);
                if (leds === pin(bin(4'd15))) lit++;
                else if (leds !== 6'b111111) bad++;
            end
            checks++;
            if (lit !== exp_lit[i] || bad !== 0) begin
                failures++;
                $display("FAIL pwm_b%0d: lit=%0d stray=%0d expected lit=%0d stray=0", b_tbl[i], lit, bad, exp_lit[i]);
            end
        end
        brightness = 2'd3;
    endtask

    initial begin
        test_reset();
        test_binary();
        test_bar();
        test_change();
        test_walk();
        test_pwm();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
